// File: rtl/freq_display.sv
// Binary-to-BCD conversion (sequential double-dabble) feeding a 4-digit,
// common-anode, time-multiplexed 7-segment display with leading-zero blanking.
module freq_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  FREQ,
    output logic [11:0] BCD,
    output logic        BUSY,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_last;
    logic [2:0]  r_shcnt;
    logic [19:0] r_shreg;
    logic [11:0] r_bcd;
    logic        r_busy;
    logic        w_start;

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_next;
    logic             w_wrap;
    logic             w_refresh;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic [6:0]       w_digit_seg;

    function automatic logic [3:0] dd_adj(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    // One double-dabble iteration: correct every BCD nibble, then shift left.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] a;
        a = {dd_adj(s[19:16]), dd_adj(s[15:12]), dd_adj(s[11:8]), s[7:0]};
        return {a[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign w_start = (r_state == S_IDLE) && (FREQ != r_last);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_SHIFT;
            S_SHIFT: if (r_shcnt == 3'd7) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_last  <= 8'd0;
            r_shcnt <= 3'd0;
            r_busy  <= 1'b0;
            r_bcd   <= 12'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_last  <= FREQ;
                        r_shcnt <= 3'd0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SHIFT: r_shcnt <= r_shcnt + 3'd1;
                S_DONE: begin
                    r_bcd  <= r_shreg[19:8];
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Datapath shift register carries no reset; it is always reloaded on start.
    always_ff @(posedge CLK) begin
        if (r_state == S_IDLE && w_start) begin
            r_shreg <= {12'd0, FREQ};
        end else if (r_state == S_SHIFT) begin
            r_shreg <= dd_step(r_shreg);
        end
    end

    assign w_wrap     = (r_cnt == CNT_MAX);
    assign w_idx_next = w_wrap ? (r_idx + 2'd1) : r_idx;
    // Reload on digit change, and once right after reset so digit 0 lights at once.
    assign w_refresh  = w_wrap || (r_an == 4'b1111);

    always_comb begin
        w_digit_seg = 7'h7F;
        case (w_idx_next)
            2'd0: w_digit_seg = seg_decode(r_bcd[3:0]);
            2'd1: if (r_bcd[11:4] != 8'd0) w_digit_seg = seg_decode(r_bcd[7:4]);
            2'd2: if (r_bcd[11:8] != 4'd0) w_digit_seg = seg_decode(r_bcd[11:8]);
            default: w_digit_seg = 7'h7F;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
            r_an  <= 4'b1111;
            r_seg <= 7'h7F;
        end else begin
            r_cnt <= w_wrap ? '0 : (r_cnt + 1'b1);
            r_idx <= w_idx_next;
            if (w_refresh) begin
                r_an  <= ~(4'b0001 << w_idx_next);
                r_seg <= w_digit_seg;
            end
        end
    end

    assign BCD  = r_bcd;
    assign BUSY = r_busy;
    assign AN   = r_an;
    assign SEG  = r_seg;
    assign DP   = 1'b1;

endmodule
